// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the character-LCD timing engine.
//   - lcd_state_e : engine FSM states
//   - init byte constants and init count for the optional power-up sequence
//   - HD44780 clear/home command codes and is_long_cmd() classifier
//   - max_u() helper used to size the shared phase counter
package lcd_pkg;

  typedef enum logic [2:0] {
    StPwrup,
    StInitLoad,
    StSetup,
    StEnHi,
    StHold,
    StWait,
    StIdle
  } lcd_state_e;

  // HD44780 command codes; 0x03 also decodes as "home" since DB0 is don't-care.
  localparam logic [7:0] CmdClr  = 8'h01;
  localparam logic [7:0] CmdHome = 8'h02;

  localparam int unsigned InitCount   = 4;
  localparam logic [7:0]  InitFuncSet = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0]  InitDispOn  = 8'h0C;  // display on, cursor off
  localparam logic [7:0]  InitClear   = CmdClr;
  localparam logic [7:0]  InitEntry   = 8'h06;  // increment, no shift

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0: b = InitFuncSet;
      2'd1: b = InitDispOn;
      2'd2: b = InitClear;
      2'd3: b = InitEntry;
      default: b = InitEntry;
    endcase
    return b;
  endfunction

  // Clear and home need the long execution wait; everything else, including 0x00, is short.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CmdClr) || (data == CmdHome) || (data == 8'h03));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter shared by every phase of the LCD engine.
//   i_clk   : clock
//   i_rst   : asynchronous active-low reset, counter returns to RST_VALUE
//   i_load  : load i_value this cycle (takes priority over counting)
//   i_value : value to load; a phase of N cycles is loaded with N-1
//   o_done  : counter has reached zero
module lcd_timer #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_done
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_value;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      count_q <= RST_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_done = (count_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-compatible character-LCD timing engine.
// Accepts byte writes over valid/ready and sequences setup, enable pulse, hold and
// execution wait on the LCD pins. Optional power-up init is enabled by defining LCD_INIT_EN.
//   i_clk, i_rst          : clock, asynchronous active-low reset
//   i_valid, i_rs, i_data : write request, register select, byte
//   o_ready               : idle, write accepted on i_valid && o_ready
//   o_init_done           : sticky once IDLE is first reached
//   o_lcd_data/rs/rw/en   : LCD bus (RW tied low, write-only)
//   o_lcd_on, o_lcd_blon  : LCD power and backlight
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned T_PWRUP = 750_000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN_HI = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_CMD   = 2_000,
  parameter int unsigned T_CLR   = 82_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic [7:0] o_lcd_data,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_en,
  output logic       o_lcd_on,
  output logic       o_lcd_blon
);

  localparam int unsigned MaxT = max_u(max_u(max_u(T_PWRUP, T_SETUP), max_u(T_EN_HI, T_HOLD)),
                                       max_u(T_CMD, T_CLR));
  localparam int unsigned CW   = $clog2(MaxT + 1);

  // Phase lengths are loaded as N-1 so each phase lasts exactly N cycles.
  localparam logic [CW-1:0] LdPwrup = CW'(T_PWRUP - 1);
  localparam logic [CW-1:0] LdSetup = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LdEnHi  = CW'(T_EN_HI - 1);
  localparam logic [CW-1:0] LdHold  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LdCmd   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] LdClr   = CW'(T_CLR - 1);

  if (CLK_HZ < 1 || T_PWRUP < 1 || T_SETUP < 1 || T_EN_HI < 1 || T_HOLD < 1 ||
      T_CMD < 1 || T_CLR < 1) begin : g_bad_param
    $error("lcd_ctrl: every timing parameter must be at least 1");
  end

  lcd_state_e state_d, state_q;
  logic [7:0] data_d, data_q;
  logic       rs_d, rs_q;
  logic       init_done_d, init_done_q;
  logic       pwr_on_q;
  logic       tmr_load;
  logic [CW-1:0] tmr_value;
  logic       tmr_done;

`ifdef LCD_INIT_EN
  logic [2:0] idx_d, idx_q;
`endif

  lcd_timer #(
    .WIDTH     (CW),
    .RST_VALUE (LdPwrup)
  ) u_timer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (tmr_load),
    .i_value (tmr_value),
    .o_done  (tmr_done)
  );

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    tmr_load    = 1'b0;
    tmr_value   = '0;
`ifdef LCD_INIT_EN
    idx_d       = idx_q;
`endif

    unique case (state_q)
      StPwrup: begin
        if (tmr_done) begin
`ifdef LCD_INIT_EN
          state_d = StInitLoad;
`else
          state_d = StIdle;
`endif
        end
      end
      StInitLoad: begin
`ifdef LCD_INIT_EN
        data_d = init_byte(idx_q[1:0]);
        rs_d   = 1'b0;
        idx_d  = idx_q + 3'd1;
`endif
        state_d   = StSetup;
        tmr_load  = 1'b1;
        tmr_value = LdSetup;
      end
      StIdle: begin
        if (i_valid) begin
          data_d    = i_data;
          rs_d      = i_rs;
          state_d   = StSetup;
          tmr_load  = 1'b1;
          tmr_value = LdSetup;
        end
      end
      StSetup: begin
        if (tmr_done) begin
          state_d   = StEnHi;
          tmr_load  = 1'b1;
          tmr_value = LdEnHi;
        end
      end
      StEnHi: begin
        if (tmr_done) begin
          state_d   = StHold;
          tmr_load  = 1'b1;
          tmr_value = LdHold;
        end
      end
      StHold: begin
        if (tmr_done) begin
          state_d   = StWait;
          tmr_load  = 1'b1;
          tmr_value = is_long_cmd(rs_q, data_q) ? LdClr : LdCmd;
        end
      end
      StWait: begin
        if (tmr_done) begin
`ifdef LCD_INIT_EN
          state_d = (idx_q < 3'(InitCount)) ? StInitLoad : StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StPwrup;
    endcase

    // Sticky flag rises on the same edge IDLE is first entered.
    if (state_d == StIdle) begin
      init_done_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= StPwrup;
      data_q      <= 8'h00;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
      pwr_on_q    <= 1'b0;
`ifdef LCD_INIT_EN
      idx_q       <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      rs_q        <= rs_d;
      init_done_q <= init_done_d;
      pwr_on_q    <= 1'b1;
`ifdef LCD_INIT_EN
      idx_q       <= idx_d;
`endif
    end
  end

  // Outputs decode directly from registered state so reset clears E without a clock.
  assign o_ready     = (state_q == StIdle);
  assign o_lcd_en    = (state_q == StEnHi);
  assign o_init_done = init_done_q;
  assign o_lcd_data  = data_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_on    = pwr_on_q;
  assign o_lcd_blon  = pwr_on_q;

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Character-LCD timing engine downstream of the load/store unit's LCD output port. Accepts byte-wide command/data writes over a valid/ready handshake, drives HD44780-compatible pins with correct setup, enable-pulse, hold and execution-wait timing, and optionally runs the power-up initialisation sequence. This removes the need for the CPU to bit-bang LCD timing.

## Interface
- CLK_HZ, 50_000_000: clock frequency; documentation only, all timing is set by the cycle parameters below
- T_PWRUP, 750_000: cycles to wait after reset release (15 ms)
- T_SETUP, 2: cycles with RS/DATA stable before EN rises
- T_EN_HI, 12: cycles EN is held high
- T_HOLD, 2: cycles RS/DATA are held after EN falls
- T_CMD, 2_000: execution wait for normal writes (40 µs)
- T_CLR, 82_000: execution wait for clear/home (1.64 ms)
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-low
- i_valid  in  1  write request
- i_rs  in  1  0 = command, 1 = data
- i_data  in  8  byte to write
- o_ready  out  1  engine idle, can accept a write
- o_init_done  out  1  power-up init complete, sticky until reset
- o_lcd_data  out  8  LCD DB[7:0]
- o_lcd_rs  out  1  LCD RS
- o_lcd_rw  out  1  LCD RW; tied 0 (write-only)
- o_lcd_en  out  1  LCD E
- o_lcd_on  out  1  LCD power
- o_lcd_blon  out  1  backlight

## Operation
- FSM states: PWRUP → (INIT_LOAD) → SETUP → EN_HI → HOLD → WAIT → IDLE. After WAIT, the FSM returns to INIT_LOAD while init bytes remain, otherwise it goes to IDLE.
- Transfer occurs on a rising edge where i_valid && o_ready. i_rs and i_data are captured on that edge.
- o_ready is high only in IDLE.
- While o_ready is low, i_valid is ignored and nothing is queued. Upstream holds its request.
- SETUP: drive the captured RS/DATA, E=0.
- EN_HI: E=1.
- HOLD: E=0, RS/DATA unchanged.
- WAIT: E=0. RS/DATA hold their last values until the next transfer.
- Clear/home detection: RS=0 and data ∈ {0x01, 0x02, 0x03} uses T_CLR. Every other byte, including 0x00, uses T_CMD.
- Init sequence, in order: 0x38 (8-bit, 2-line), 0x0C (display on), 0x01 (clear), 0x06 (entry increment). All are sent with RS=0.
- o_init_done rises on the cycle IDLE is first entered.
- o_lcd_on and o_lcd_blon go to 1 on the first clock after reset release and stay there.
- Every parameter must be ≥1. The single shared down-counter is $clog2(max parameter + 1) bits wide.

## Timing
- Reset values: o_ready=0, o_init_done=0, o_lcd_data=0x00, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0, o_lcd_blon=0.
- Each phase lasts exactly its parameter in cycles.
- For an accepted write at edge k:
  - E rises at edge k+T_SETUP.
  - E falls at edge k+T_SETUP+T_EN_HI.
  - o_ready returns high at edge k+T_SETUP+T_EN_HI+T_HOLD+T_wait, where T_wait is T_CMD or T_CLR.
- Back-to-back: a write may be accepted on the same edge o_ready is first sampled high. Zero bubble beyond the wait time.
- Reset asserted mid-operation: all outputs go to their reset values immediately, including E=0. On release, restart from PWRUP.
- The first accepted write after reset is never earlier than power-up plus init completion.

## Configuration
- LCD_INIT_EN defined: PWRUP wait, then the four-byte init sequence, then IDLE. o_init_done=1 after the sequence.
- LCD_INIT_EN undefined: PWRUP wait, then straight to IDLE with o_init_done=1. Software performs initialisation.

## Structure
- Package lcd_pkg holds:
  - the state enum
  - the init byte constants and init count (4)
  - the command codes CLR=0x01 and HOME=0x02
  - the is_long_cmd function
- Sub-module lcd_timer: loadable down-counter with i_load, i_value, o_done. One instance is shared across all phases.

## Test plan
Run all scenarios with small parameters: T_PWRUP=20, T_SETUP=2, T_EN_HI=3, T_HOLD=2, T_CMD=10, T_CLR=30.
- Init enabled, reset release → E pulses exactly 4 times with DATA 0x38, 0x0C, 0x01, 0x06 and RS=0. Gap after 0x01 is 30 cycles. Then o_init_done=1 and o_ready=1.
- Write RS=1, 0x41 at edge k → E high exactly during edges k+2..k+5. o_ready back at k+17.
- Write RS=0, 0x01 → o_ready returns 37 cycles after acceptance. RS=1, 0x01 → returns after 17 cycles.
- i_valid toggling with changing data while busy → no extra E pulse, and DATA still shows the captured byte.
- Reset asserted while E=1 → E=0 in the same cycle. After release, no E pulse until the PWRUP count elapses.
- Init macro undefined → o_ready=1 and o_init_done=1 at 20 cycles after release, with no E pulses before then.
